// File: rtl/mul_share_pkg.sv
// Shared definitions for the shared-multiplier arbiter: FSM encoding and datapath widths.
package mul_share_pkg;

  localparam int OP_W  = 32;
  localparam int RES_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mul_share_arbiter_rr_pick.sv
// Combinational round-robin picker: the first asserted request after ptr wins, wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] grant,
  output logic             any_req
);

  // Index of the requester k positions after ptr, wrapped into 0..NREQ-1.
  function automatic logic [PTR_W-1:0] slot(input logic [PTR_W-1:0] p, input int k);
    int s;
    s = (int'(p) + k) % NREQ;
    return PTR_W'(s);
  endfunction

  // Scan from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[slot(ptr, k)]) begin
        grant   = slot(ptr, k);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_share_arbiter_xmult.sv
// XMult: full-precision signed 32x32 -> 64 combinational multiplier with its own overflow flag.
module XMult
  import mul_share_pkg::*;
(
  input  logic signed [OP_W-1:0]  a,
  input  logic signed [OP_W-1:0]  b,
  output logic signed [RES_W-1:0] product,
  output logic                    overflow
);

  logic signed [RES_W-1:0] a_x;
  logic signed [RES_W-1:0] b_x;

  // Sign-extend first so the 64-bit product is exact for every operand pair.
  assign a_x      = RES_W'(a);
  assign b_x      = RES_W'(b);
  assign product  = a_x * b_x;
  assign overflow = ~((&product[RES_W-1:OP_W-1]) | ~(|product[RES_W-1:OP_W-1]));

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one signed 32x32 multiplier among NREQ requesters with round-robin grant,
// valid/ready handshakes on both sides and registered results with an overflow flag.
module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*OP_W-1:0]     req_a,
  input  logic [NREQ*OP_W-1:0]     req_b,
  output logic [NREQ-1:0]          rsp_valid,
  input  logic [NREQ-1:0]          rsp_ready,
  output logic signed [RES_W-1:0]  rsp_result,
  output logic                     rsp_overflow,
  output logic [PTR_W-1:0]         rsp_id,
  output logic                     busy
);

  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  // True when the product does not fit in a signed 32-bit word (bits 63..31 not all equal).
  function automatic logic ovf32(input logic signed [RES_W-1:0] p);
    return !((&p[RES_W-1:OP_W-1]) || !(|p[RES_W-1:OP_W-1]));
  endfunction

  state_e                  state;
  logic [PTR_W-1:0]        ptr;
  logic [PTR_W-1:0]        grant;
  logic                    any_req;
  logic signed [OP_W-1:0]  a_lane [NREQ];
  logic signed [OP_W-1:0]  b_lane [NREQ];
  logic signed [OP_W-1:0]  a_p0;
  logic signed [OP_W-1:0]  b_p0;
  logic [PTR_W-1:0]        id_p0;
  logic signed [RES_W-1:0] product;
  logic signed [RES_W-1:0] res_p1;
  logic                    ovf_p1;
  logic [NREQ-1:0]         vld_p1;
  logic                    busy_q;
  logic                    rsp_hs;

  // Unpack the flat operand buses into per-requester lanes.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      a_lane[i] = req_a[i*OP_W +: OP_W];
      b_lane[i] = req_b[i*OP_W +: OP_W];
    end
  end

  rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req     (req_valid),
    .ptr     (ptr),
    .grant   (grant),
    .any_req (any_req)
  );

  // Accept strobe exists only in IDLE and is suppressed while reset is held.
  assign req_ready = (reset && state == IDLE && any_req) ? (ONE << grant) : '0;

  // Only the owner's rsp_ready counts, since vld_p1 is one-hot on the owner.
  assign rsp_hs = |(vld_p1 & rsp_ready);

  // Overflow output of XMult is not needed; the flag is formed from the product here.
  XMult u_mul (
    .a        (a_p0),
    .b        (b_p0),
    .product  (product),
    .overflow ()
  );

  // Control FSM with registered operands, result and response strobes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      ptr    <= PTR_W'(NREQ - 1);
      a_p0   <= '0;
      b_p0   <= '0;
      id_p0  <= '0;
      res_p1 <= '0;
      ovf_p1 <= 1'b0;
      vld_p1 <= '0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        // p0: accept handshake, capture the winner's operands and index
        IDLE: begin
          if (any_req) begin
            a_p0   <= a_lane[grant];
            b_p0   <= b_lane[grant];
            id_p0  <= grant;
            busy_q <= 1'b1;
            state  <= MUL;
          end
        end
        // p1: multiplier output registered together with its overflow flag
        MUL: begin
          res_p1 <= product;
          ovf_p1 <= ovf32(product);
          vld_p1 <= ONE << id_p0;
          state  <= RESP;
        end
        // response held until the owner accepts; owner becomes the new lowest priority
        RESP: begin
          if (rsp_hs) begin
            ptr    <= id_p0;
            vld_p1 <= '0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp_valid    = vld_p1;
  assign rsp_result   = res_p1;
  assign rsp_overflow = ovf_p1;
  assign rsp_id       = id_p0;
  assign busy         = busy_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed, table-driven bench for mul_share_arbiter with hand-written multi-cycle sequences.
module tb_mul_share_arbiter;

  logic              clk;
  logic              reset;
  logic [3:0]        req_valid;
  logic [3:0]        req_ready;
  logic [127:0]      req_a;
  logic [127:0]      req_b;
  logic [3:0]        rsp_valid;
  logic [3:0]        rsp_ready;
  logic signed [63:0] rsp_result;
  logic              rsp_overflow;
  logic [1:0]        rsp_id;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int                 idx;
    logic signed [31:0] a;
    logic signed [31:0] b;
    logic signed [63:0] exp;
    logic               ovf;
    string              name;
  } vec_t;

  vec_t vecs [12];

  mul_share_arbiter #(
    .NREQ  (4),
    .PTR_W (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_overflow (rsp_overflow),
    .rsp_id       (rsp_id),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] oh(input int i);
    logic [3:0] one;
    one = 4'b0001;
    return one << i;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b0;
    req_valid = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Starts and ends at a negedge with the DUT in IDLE; rsp_ready held high throughout.
  task automatic run_single(input vec_t v);
    req_valid = oh(v.idx);
    req_a[v.idx*32 +: 32] = v.a;
    req_b[v.idx*32 +: 32] = v.b;
    rsp_ready = 4'b1111;
    #1 check({v.name, "_ready"}, 64'(req_ready), 64'(oh(v.idx)));
    @(negedge clk);
    req_valid = '0;
    req_a     = '1;
    req_b     = '1;
    check({v.name, "_mul_vld"}, 64'(rsp_valid), 64'd0);
    check({v.name, "_mul_busy"}, 64'(busy), 64'd1);
    @(negedge clk);
    check({v.name, "_vld"}, 64'(rsp_valid), 64'(oh(v.idx)));
    check({v.name, "_res"}, rsp_result, v.exp);
    check({v.name, "_ovf"}, 64'(rsp_overflow), 64'(v.ovf));
    check({v.name, "_id"}, 64'(rsp_id), 64'(v.idx));
    @(negedge clk);
    check({v.name, "_post_vld"}, 64'(rsp_valid), 64'd0);
    check({v.name, "_post_busy"}, 64'(busy), 64'd0);
    check({v.name, "_post_res"}, rsp_result, v.exp);
    req_a = '0;
    req_b = '0;
  endtask

  initial begin
    vecs[0]  = '{0, 32'sd5, -32'sd7, -64'sd35, 1'b0, "single_5x-7"};
    vecs[1]  = '{1, 32'sd2, 32'sd3, 64'sd6, 1'b0, "t_2x3"};
    vecs[2]  = '{2, -32'sd12, -32'sd4, 64'sd48, 1'b0, "t_-12x-4"};
    vecs[3]  = '{3, -32'sd9, 32'sd5, -64'sd45, 1'b0, "t_-9x5"};
    vecs[4]  = '{0, 32'sd11, 32'sd0, 64'sd0, 1'b0, "t_11x0"};
    vecs[5]  = '{1, 32'sh4000_0000, 32'sd4, 64'sh1_0000_0000, 1'b1, "ovf_2^30x4"};
    vecs[6]  = '{2, -32'sd65536, 32'sd32768, -64'sd2147483648, 1'b0, "edge_-2^31"};
    vecs[7]  = '{3, -32'sd1, -32'sd7, 64'sd7, 1'b0, "t_-1x-7"};
    vecs[8]  = '{0, 32'sh8000_0000, 32'sh8000_0000, 64'sh4000_0000_0000_0000, 1'b1, "ovf_min_sq"};
    vecs[9]  = '{1, 32'sh7fff_ffff, 32'sd1, 64'sd2147483647, 1'b0, "edge_maxpos"};
    vecs[10] = '{2, 32'sd65536, 32'sd32768, 64'sd2147483648, 1'b1, "ovf_+2^31"};
    vecs[11] = '{3, 32'sh8000_0000, 32'sd1, -64'sd2147483648, 1'b0, "edge_minneg"};

    reset     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_result", rsp_result, 64'd0);
    check("rst_ovf", 64'(rsp_overflow), 64'd0);
    check("rst_id", 64'(rsp_id), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset = 1'b1;

    // Table of single transactions, one requester at a time.
    for (int i = 0; i < 12; i++) run_single(vecs[i]);

    // Simultaneous requests from all four: grants 0,1,2,3, responses 3 cycles apart.
    do_reset();
    req_a = {32'sd11, -32'sd9, -32'sd12, 32'sd2};
    req_b = {32'sd0, 32'sd5, -32'sd4, 32'sd3};
    req_valid = 4'b1111;
    rsp_ready = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      #1 check("sim_ready", 64'(req_ready), 64'(oh(k)));
      @(negedge clk);
      req_valid[k] = 1'b0;
      check("sim_mul_vld", 64'(rsp_valid), 64'd0);
      @(negedge clk);
      check("sim_vld", 64'(rsp_valid), 64'(oh(k)));
      check("sim_id", 64'(rsp_id), 64'(k));
      case (k)
        0: check("sim_res0", rsp_result, 64'sd6);
        1: check("sim_res1", rsp_result, 64'sd48);
        2: check("sim_res2", rsp_result, -64'sd45);
        default: check("sim_res3", rsp_result, 64'sd0);
      endcase
      @(negedge clk);
    end
    req_a = '0;
    req_b = '0;

    // Backpressure on requester 1 while 0 and 3 wait.
    do_reset();
    req_valid = 4'b0010;
    req_a[63:32] = 32'sd4;
    req_b[63:32] = 32'sd6;
    rsp_ready = 4'b1101;
    #1 check("bp_ready", 64'(req_ready), 64'(oh(1)));
    @(negedge clk);
    req_valid = 4'b1001;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_vld", 64'(rsp_valid), 64'(oh(1)));
      check("bp_res", rsp_result, 64'sd24);
      check("bp_busy", 64'(busy), 64'd1);
      check("bp_no_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    rsp_ready = 4'b1111;
    @(negedge clk);
    #1 check("bp_next_grant", 64'(req_ready), 64'(oh(3)));
    check("bp_res_held", rsp_result, 64'sd24);
    req_valid = '0;
    @(negedge clk);
    check("bp_skip_busy", 64'(busy), 64'd0);
    check("bp_skip_ready", 64'(req_ready), 64'd0);

    // Reset during MUL drops the transaction; requester 2 is re-granted afterwards.
    do_reset();
    req_a[95:64] = -32'sd3;
    req_b[95:64] = 32'sd1000;
    req_valid = 4'b0100;
    rsp_ready = 4'b1111;
    #1 check("rm_ready", 64'(req_ready), 64'(oh(2)));
    @(negedge clk);
    check("rm_in_mul", 64'(busy), 64'd1);
    reset = 1'b0;
    @(negedge clk);
    check("rm_ready0", 64'(req_ready), 64'd0);
    check("rm_vld0", 64'(rsp_valid), 64'd0);
    check("rm_res0", rsp_result, 64'd0);
    check("rm_ovf0", 64'(rsp_overflow), 64'd0);
    check("rm_id0", 64'(rsp_id), 64'd0);
    check("rm_busy0", 64'(busy), 64'd0);
    reset = 1'b1;
    #1 check("rm_regrant", 64'(req_ready), 64'(oh(2)));
    @(negedge clk);
    req_valid = '0;
    check("rm_mul_vld", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    check("rm_vld", 64'(rsp_valid), 64'(oh(2)));
    check("rm_res", rsp_result, -64'sd3000);
    check("rm_id", 64'(rsp_id), 64'd2);
    @(negedge clk);

    // Fairness: 0 and 2 held high alternate; 1 and 3 never appear.
    do_reset();
    req_a = '0;
    req_b = '0;
    req_a[31:0]  = 32'sd3;
    req_b[31:0]  = 32'sd3;
    req_a[95:64] = -32'sd2;
    req_b[95:64] = 32'sd7;
    req_valid = 4'b0101;
    rsp_ready = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1 check("fair_ready", 64'(req_ready), 64'(oh((k % 2) * 2)));
      @(negedge clk);
      @(negedge clk);
      check("fair_id", 64'(rsp_id), 64'((k % 2) * 2));
      check("fair_res", rsp_result, (k % 2 == 0) ? 64'sd9 : -64'sd14);
      @(negedge clk);
    end
    req_valid = '0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
